decode_stage: RTL and testbench

- Registered, parametrised successor to the combinational control decoder.
- Accepts fetched instructions and their PC over a valid/ready handshake, and expands compressed encodings with the existing expander.
- Decodes register indices, immediate, funct fields and write enables, and flags illegal encodings.
- Holds results in a BUF_DEPTH-entry output FIFO feeding the execute stage. Supports RV32 and RV64 (OP-32/OP-IMM-32), with synchronous flush for branch redirect.

---
 rtl/decode_stage_if.sv | 44 ++++
 rtl/decode_stage.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Bundle of the fetch-side and execute-side handshakes of the decode stage.
//
//   in_valid / in_ready / in_instr / in_pc     : fetched instruction stream
//   out_valid / out_ready / out_*              : decoded head entry to execute
//
// master : the surrounding pipeline (drives the fetch side, consumes results)
// slave  : the decode stage itself
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_opcode;
    logic            out_rd_we;
    logic            out_mm_we;
    logic            out_comp;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_opcode, out_rd_we, out_mm_we,
               out_comp, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_opcode, out_rd_we, out_mm_we,
               out_comp, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage.
// Expands compressed instructions, decodes register indices, immediate,
// funct fields and write enables, flags illegal encodings, and queues the
// result in a BUF_DEPTH-entry FIFO feeding the execute stage.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous discard of all buffered and incoming instructions
//   bus    : decode_stage_if.slave (fetch handshake in, decoded entry out)
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter bit SUPPORT_C = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    localparam bit RV64  = (XLEN == 64);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      opcode;
        logic            rd_we;
        logic            mm_we;
        logic            comp;
        logic            illegal;
    } entry_t;

    // Compressed expander: returns {illegal, expanded 32-bit instruction}.
    // Reserved and floating-point encodings come back as illegal with a zero word.
    function automatic logic [32:0] expand(input logic [15:0] c);
        logic [4:0]  rdp;
        logic [4:0]  rs1p;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [31:0] inst;
        logic        ill;
        rdp  = {2'b01, c[4:2]};
        rs1p = {2'b01, c[9:7]};
        rd   = c[11:7];
        rs2  = c[6:2];
        inst = '0;
        ill  = 1'b0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                inst = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'b0010011};
                ill  = (c[12:5] == 8'h00);
            end
            5'b00_010: inst = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'b0000011};
            5'b00_011: begin
                inst = {4'b0, c[6:5], c[12:10], 3'b000, rs1p, 3'b011, rdp, 7'b0000011};
                ill  = !RV64;
            end
            5'b00_110: inst = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
            5'b00_111: begin
                inst = {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011, c[11:10], 3'b000, 7'b0100011};
                ill  = !RV64;
            end
            5'b01_000: inst = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'b0010011};
            5'b01_001: begin
                // c.jal on RV32, c.addiw on RV64
                if (RV64) begin
                    inst = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'b0011011};
                    ill  = (rd == 5'd0);
                end else begin
                    inst = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                            c[12], {8{c[12]}}, 5'd1, 7'b1101111};
                end
            end
            5'b01_010: inst = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'b0010011};
            5'b01_011: begin
                if (rd == 5'd2) begin
                    inst = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
                end else begin
                    inst = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
                end
                ill = ({c[12], c[6:2]} == 6'd0);
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: inst = {6'b000000, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                    2'b01: inst = {6'b010000, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                    2'b10: inst = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, 7'b0010011};
                    default: begin
                        case ({c[12], c[6:5]})
                            3'b000: inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                            3'b001: inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                            3'b010: inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                            3'b011: inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
                            3'b100: begin
                                inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0111011};
                                ill  = !RV64;
                            end
                            3'b101: begin
                                inst = {7'b0000000, rdp, rs1p, 3'b000, rs1p, 7'b0111011};
                                ill  = !RV64;
                            end
                            default: ill = 1'b1;
                        endcase
                    end
                endcase
            end
            5'b01_101: inst = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                               c[12], {8{c[12]}}, 5'd0, 7'b1101111};
            5'b01_110,
            5'b01_111: inst = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13],
                               c[11:10], c[4:3], c[12], 7'b1100011};
            5'b10_000: inst = {6'b000000, c[12], c[6:2], rd, 3'b001, rd, 7'b0010011};
            5'b10_010: begin
                inst = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
                ill  = (rd == 5'd0);
            end
            5'b10_011: begin
                inst = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'd2, 3'b011, rd, 7'b0000011};
                ill  = !RV64 || (rd == 5'd0);
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        inst = {12'b0, rd, 3'b000, 5'd0, 7'b1100111};
                        ill  = (rd == 5'd0);
                    end else begin
                        inst = {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
                    end
                end else if (rs2 == 5'd0 && rd == 5'd0) begin
                    inst = 32'h0010_0073;
                end else if (rs2 == 5'd0) begin
                    inst = {12'b0, rd, 3'b000, 5'd1, 7'b1100111};
                end else begin
                    inst = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
                end
            end
            5'b10_110: inst = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
            5'b10_111: begin
                inst = {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011, c[11:10], 3'b000, 7'b0100011};
                ill  = !RV64;
            end
            default: ill = 1'b1;
        endcase
        if (ill) inst = '0;
        return {ill, inst};
    endfunction

    logic             is_c;
    logic [32:0]      c_exp;
    logic [31:0]      instr;
    logic [4:0]       op;
    fmt_t             fmt;
    logic             known;
    logic             wr_class;
    logic             is_shift;
    logic [6:0]       funct7;
    logic [63:0]      imm64;
    entry_t           dec;

    entry_t           mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    entry_t           head;

    // Decode of the incoming instruction; the whole result is stored with the
    // FIFO entry so the execute side never sees the raw encoding.
    always_comb begin
        is_c     = (bus.in_instr[1:0] != 2'b11);
        c_exp    = expand(bus.in_instr[15:0]);
        instr    = bus.in_instr;
        dec      = '0;
        fmt      = FMT_R;
        known    = 1'b1;
        wr_class = 1'b0;
        imm64    = '0;
        if (is_c && SUPPORT_C) begin
            instr       = c_exp[31:0];
            dec.comp    = 1'b1;
            dec.illegal = c_exp[32];
        end
        // Without compressed support a 16-bit encoding reaches here unexpanded
        // and fails this check.
        if (instr[1:0] != 2'b11) dec.illegal = 1'b1;
        if (bus.in_instr[15:0] == 16'h0000 || bus.in_instr == 32'hFFFF_FFFF) dec.illegal = 1'b1;
        op = instr[6:2];
        case (op)
            OPC_LOAD:      begin fmt = FMT_I; wr_class = 1'b1; end
            OPC_MISC_MEM:  fmt = FMT_R;
            OPC_OP_IMM:    begin fmt = FMT_I; wr_class = 1'b1; end
            OPC_AUIPC:     begin fmt = FMT_U; wr_class = 1'b1; end
            OPC_OP_IMM_32: begin fmt = FMT_I; wr_class = 1'b1; known = RV64; end
            OPC_STORE:     fmt = FMT_S;
            OPC_OP:        begin fmt = FMT_R; wr_class = 1'b1; end
            OPC_LUI:       begin fmt = FMT_U; wr_class = 1'b1; end
            OPC_OP_32:     begin fmt = FMT_R; wr_class = 1'b1; known = RV64; end
            OPC_BRANCH:    fmt = FMT_B;
            OPC_JALR:      begin fmt = FMT_I; wr_class = 1'b1; end
            OPC_JAL:       begin fmt = FMT_J; wr_class = 1'b1; end
            OPC_SYSTEM:    fmt = FMT_I;
            default:       known = 1'b0;
        endcase
        if (!known) dec.illegal = 1'b1;

        case (fmt)
            FMT_I:   imm64 = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_J:   imm64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm64 = '0;
        endcase
        funct7 = (fmt == FMT_R) ? instr[31:25] : 7'd0;

        // Shift amounts are 6 bits wide only for full-width RV64 shifts; the
        // low funct7 bit then belongs to the shamt.
        is_shift = (op == OPC_OP_IMM || op == OPC_OP_IMM_32) && (instr[13:12] == 2'b01);
        if (is_shift) begin
            if (RV64 && op == OPC_OP_IMM) begin
                imm64  = {58'd0, instr[25:20]};
                funct7 = {instr[31:26], 1'b0};
            end else begin
                imm64  = {59'd0, instr[24:20]};
                funct7 = instr[31:25];
            end
        end

        if (dec.illegal) begin
            imm64    = '0;
            funct7   = '0;
            wr_class = 1'b0;
        end

        dec.pc     = bus.in_pc;
        dec.imm    = imm64[XLEN-1:0];
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = funct7;
        dec.opcode = op;
        dec.rd_we  = wr_class && (instr[11:7] != 5'd0);
        dec.mm_we  = (op == OPC_STORE) && !dec.illegal;
    end

    // Handshake: in_ready depends on occupancy only, so out_ready never
    // reaches the fetch side combinationally. Flush suppresses both moves.
    assign bus.in_ready  = (count < CNT_W'(BUF_DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready && !flush;
    assign pop           = bus.out_valid && bus.out_ready && !flush;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy and pointers; flush empties the FIFO in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head = bus.out_valid ? mem[rd_ptr] : '0;

    assign bus.out_pc      = head.pc;
    assign bus.out_imm     = head.imm;
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_funct3  = head.funct3;
    assign bus.out_funct7  = head.funct7;
    assign bus.out_opcode  = head.opcode;
    assign bus.out_rd_we   = head.rd_we;
    assign bus.out_mm_we   = head.mm_we;
    assign bus.out_comp    = head.comp;
    assign bus.out_illegal = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
// Three instances share one stimulus stream:
//   dut_a : XLEN=32, BUF_DEPTH=2, SUPPORT_C=1
//   dut_b : XLEN=64, BUF_DEPTH=2, SUPPORT_C=1
//   dut_c : XLEN=32, BUF_DEPTH=2, SUPPORT_C=0
module tb_decode_stage;
    logic clk;
    logic rst_n;
    logic flush;
    int   compared;
    int   mismatched;

    decode_stage_if #(.XLEN(32)) ifa ();
    decode_stage_if #(.XLEN(64)) ifb ();
    decode_stage_if #(.XLEN(32)) ifc ();

    decode_stage #(.XLEN(32), .BUF_DEPTH(2), .SUPPORT_C(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa.slave));
    decode_stage #(.XLEN(64), .BUF_DEPTH(2), .SUPPORT_C(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb.slave));
    decode_stage #(.XLEN(32), .BUF_DEPTH(2), .SUPPORT_C(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the same fetch-side inputs and out_ready into every instance.
    task automatic apply_stimulus(input logic valid, input logic [31:0] instr,
                                  input logic [63:0] pc, input logic ready);
        ifa.in_valid = valid; ifa.in_instr = instr; ifa.in_pc = pc[31:0]; ifa.out_ready = ready;
        ifb.in_valid = valid; ifb.in_instr = instr; ifb.in_pc = pc;       ifb.out_ready = ready;
        ifc.in_valid = valid; ifc.in_instr = instr; ifc.in_pc = pc[31:0]; ifc.out_ready = ready;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1);
        #3;
        check_output("rst_valid_a", ifa.out_valid, 0);
        check_output("rst_valid_b", ifb.out_valid, 0);
        check_output("rst_valid_c", ifc.out_valid, 0);
        check_output("rst_pc_a", ifa.out_pc, 0);
        check_output("rst_imm_b", ifb.out_imm, 0);
        check_output("rst_illegal_b", ifb.out_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_output("post_rst_ready_a", ifa.in_ready, 1);
        check_output("post_rst_ready_b", ifb.in_ready, 1);
        check_output("post_rst_ready_c", ifc.in_ready, 1);

        // ADDI x1, x0, 5
        apply_stimulus(1'b1, ADDI, 64'h100, 1'b1);
        step();
        check_output("addi_valid_a", ifa.out_valid, 1);
        check_output("addi_rd_a", ifa.out_rd, 1);
        check_output("addi_rs1_a", ifa.out_rs1, 0);
        check_output("addi_imm_a", ifa.out_imm, 5);
        check_output("addi_rdwe_a", ifa.out_rd_we, 1);
        check_output("addi_mmwe_a", ifa.out_mm_we, 0);
        check_output("addi_illegal_a", ifa.out_illegal, 0);
        check_output("addi_pc_a", ifa.out_pc, 64'h100);
        check_output("addi_opcode_a", ifa.out_opcode, 5'b00100);
        check_output("addi_comp_a", ifa.out_comp, 0);
        check_output("addi_imm_c", ifc.out_imm, 5);

        // SRAI x2, x3, 33 on RV64 (back-to-back: ADDI pops on this edge)
        apply_stimulus(1'b1, 32'h4211_D113, 64'h104, 1'b1);
        step();
        check_output("srai_pc_b", ifb.out_pc, 64'h104);
        check_output("srai_imm_b", ifb.out_imm, 33);
        check_output("srai_f7_b", ifb.out_funct7, 7'h20);
        check_output("srai_f3_b", ifb.out_funct3, 5);
        check_output("srai_rd_b", ifb.out_rd, 2);
        check_output("srai_rs1_b", ifb.out_rs1, 3);
        check_output("srai_imm_a", ifa.out_imm, 1);
        check_output("srai_f7_a", ifa.out_funct7, 7'h21);
        check_output("srai_f7_c", ifc.out_funct7, 7'h21);

        // C.ADDI x1, 1
        apply_stimulus(1'b1, 32'h0000_0085, 64'h108, 1'b1);
        step();
        check_output("caddi_comp_a", ifa.out_comp, 1);
        check_output("caddi_rd_a", ifa.out_rd, 1);
        check_output("caddi_rs1_a", ifa.out_rs1, 1);
        check_output("caddi_imm_a", ifa.out_imm, 1);
        check_output("caddi_opcode_a", ifa.out_opcode, 5'b00100);
        check_output("caddi_rdwe_a", ifa.out_rd_we, 1);
        check_output("caddi_illegal_a", ifa.out_illegal, 0);
        check_output("caddi_imm_b", ifb.out_imm, 1);
        check_output("caddi_illegal_c", ifc.out_illegal, 1);
        check_output("caddi_rdwe_c", ifc.out_rd_we, 0);

        // SW x1, 8(x2)
        apply_stimulus(1'b1, 32'h0011_2423, 64'h10A, 1'b1);
        step();
        check_output("sw_mmwe_a", ifa.out_mm_we, 1);
        check_output("sw_rdwe_a", ifa.out_rd_we, 0);
        check_output("sw_imm_a", ifa.out_imm, 8);
        check_output("sw_rs1_a", ifa.out_rs1, 2);
        check_output("sw_rs2_a", ifa.out_rs2, 1);
        check_output("sw_opcode_a", ifa.out_opcode, 5'b01000);

        // LUI x1, 0xFFFFF (sign extension to XLEN)
        apply_stimulus(1'b1, 32'hFFFF_F0B7, 64'h10E, 1'b1);
        step();
        check_output("lui_imm_a", ifa.out_imm, 64'h0000_0000_FFFF_F000);
        check_output("lui_imm_b", ifb.out_imm, 64'hFFFF_FFFF_FFFF_F000);
        check_output("lui_rdwe_b", ifb.out_rd_we, 1);

        // ADDIW x1, x1, 1: legal only on RV64
        apply_stimulus(1'b1, 32'h0010_809B, 64'h112, 1'b1);
        step();
        check_output("addiw_illegal_a", ifa.out_illegal, 1);
        check_output("addiw_rdwe_a", ifa.out_rd_we, 0);
        check_output("addiw_imm_a", ifa.out_imm, 0);
        check_output("addiw_illegal_b", ifb.out_illegal, 0);
        check_output("addiw_rdwe_b", ifb.out_rd_we, 1);
        check_output("addiw_imm_b", ifb.out_imm, 1);

        // c.unimp
        apply_stimulus(1'b1, 32'h0000_0000, 64'h116, 1'b1);
        step();
        check_output("zero_illegal_a", ifa.out_illegal, 1);
        check_output("zero_imm_a", ifa.out_imm, 0);
        check_output("zero_rdwe_a", ifa.out_rd_we, 0);
        check_output("zero_illegal_b", ifb.out_illegal, 1);
        check_output("zero_illegal_c", ifc.out_illegal, 1);

        // All-ones word
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 64'h118, 1'b1);
        step();
        check_output("ones_illegal_a", ifa.out_illegal, 1);
        check_output("ones_imm_a", ifa.out_imm, 0);
        check_output("ones_illegal_c", ifc.out_illegal, 1);

        apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1);
        step();
        check_output("drain_valid_a", ifa.out_valid, 0);
        check_output("drain_ready_a", ifa.in_ready, 1);

        // Backpressure: pc 0, 4 fill the FIFO, pc 8 waits
        apply_stimulus(1'b1, ADDI, 64'h0, 1'b0);
        step();
        check_output("bp1_ready_a", ifa.in_ready, 1);
        check_output("bp1_pc_a", ifa.out_pc, 0);
        apply_stimulus(1'b1, ADDI, 64'h4, 1'b0);
        step();
        check_output("bp2_ready_a", ifa.in_ready, 0);
        check_output("bp2_pc_a", ifa.out_pc, 0);
        apply_stimulus(1'b1, ADDI, 64'h8, 1'b0);
        step();
        check_output("bp3_ready_a", ifa.in_ready, 0);
        check_output("bp3_pc_stable_a", ifa.out_pc, 0);
        check_output("bp3_valid_a", ifa.out_valid, 1);
        apply_stimulus(1'b1, ADDI, 64'h8, 1'b1);
        #1;
        check_output("bp_no_comb_ready_a", ifa.in_ready, 0);
        step();
        check_output("bp4_pc_a", ifa.out_pc, 4);
        check_output("bp4_pc_b", ifb.out_pc, 4);
        check_output("bp4_ready_a", ifa.in_ready, 1);
        step();
        check_output("bp5_pc_a", ifa.out_pc, 8);
        check_output("bp5_valid_a", ifa.out_valid, 1);
        apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1);
        step();
        check_output("bp6_valid_a", ifa.out_valid, 0);

        // Flush with a full FIFO and a pending input
        apply_stimulus(1'b1, ADDI, 64'h20, 1'b0);
        step();
        apply_stimulus(1'b1, ADDI, 64'h24, 1'b0);
        step();
        check_output("fl_full_ready_a", ifa.in_ready, 0);
        flush = 1'b1;
        apply_stimulus(1'b1, ADDI, 64'h28, 1'b0);
        step();
        flush = 1'b0;
        apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1);
        check_output("fl_valid_a", ifa.out_valid, 0);
        check_output("fl_valid_b", ifb.out_valid, 0);
        check_output("fl_ready_a", ifa.in_ready, 1);
        step();
        check_output("fl_after_valid_a", ifa.out_valid, 0);

        // Flush with one entry while a push and a pop are both offered
        apply_stimulus(1'b1, ADDI, 64'h30, 1'b0);
        step();
        flush = 1'b1;
        apply_stimulus(1'b1, ADDI, 64'h34, 1'b1);
        step();
        flush = 1'b0;
        apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1);
        check_output("fl2_valid_a", ifa.out_valid, 0);
        step();
        check_output("fl2_after_valid_a", ifa.out_valid, 0);
        check_output("fl2_after_valid_c", ifc.out_valid, 0);

        // Asynchronous reset with the FIFO full
        apply_stimulus(1'b1, ADDI, 64'h40, 1'b0);
        step();
        apply_stimulus(1'b1, ADDI, 64'h44, 1'b0);
        step();
        check_output("mr_full_valid_a", ifa.out_valid, 1);
        check_output("mr_full_ready_a", ifa.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_output("mr_valid_a", ifa.out_valid, 0);
        check_output("mr_pc_a", ifa.out_pc, 0);
        check_output("mr_imm_a", ifa.out_imm, 0);
        check_output("mr_rd_a", ifa.out_rd, 0);
        check_output("mr_rdwe_a", ifa.out_rd_we, 0);
        check_output("mr_valid_b", ifb.out_valid, 0);
        apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_output("mr_ready_a", ifa.in_ready, 1);
        check_output("mr_ready_b", ifb.in_ready, 1);
        check_output("mr_after_valid_a", ifa.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
